i2c_wr_seq: RTL and testbench
=============================

# i2c_wr_seq

Transaction sequencer that sits in front of the `i2c_send` byte engine and turns a single register-write command into a three-byte I2C write. The three bytes are device address with W, register address, and data. It feeds bytes through the engine's `pre_ready`/`pre_data` load handshake and checks the slave ACK returned with each `byte_done`. On NACK it aborts and retries the whole transaction; on timeout it reports an error. It is the only master of the byte engine's load interface.

## Interface
- `NUM_RETRY`, default 3: retries after a NACK, range 0..7. Total attempts are `NUM_RETRY+1`.
- `TIMEOUT`, default 4096: maximum number of cycles from a `pre_ready` pulse to the matching `byte_done`.
- `GAP_CYC`, default 16: idle cycles between `stop_req` and the first byte of a retry. Minimum 1.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset. Synchronous and active-high.
- `cmd_valid`, in, 1: a command is presented.
- `cmd_ready`, out, 1: the sequencer is idle and can accept a command.
- `cmd_dev`, in, 7: 7-bit slave address.
- `cmd_reg`, in, 8: register address.
- `cmd_data`, in, 8: write data.
- `pre_ready`, out, 1: one-cycle load pulse to the byte engine.
- `pre_data`, out, 8: byte to send. Valid while `pre_ready` is high.
- `pre_first`, out, 1: high with `pre_ready` on byte 0. Tells the engine to emit START before the byte.
- `pre_last`, out, 1: high with `pre_ready` on byte 2. Tells the engine to emit STOP after the ACK slot.
- `byte_done`, in, 1: one-cycle pulse from the engine when a byte and its ACK slot are complete.
- `ack_n`, in, 1: sampled SDA in the ACK slot, qualified by `byte_done`. 0 means ACK, 1 means NACK.
- `stop_req`, out, 1: one-cycle pulse asking the engine to emit STOP on abort.
- `busy`, out, 1: high from command acceptance until `done` or `err`.
- `done`, out, 1: one-cycle pulse when the transaction completes successfully.
- `err`, out, 1: one-cycle pulse when the transaction fails.
- `err_code`, out, 2: error reason, held until the next accepted command.
  - 00: none.
  - 01: NACK on the address byte.
  - 10: NACK on the register or data byte.
  - 11: timeout.
- `attempts`, out, 3: number of attempts used by the last transaction, held until the next accepted command.

## Operation
- States: IDLE, LOAD, WAIT, CHECK, GAP, FIN.
- Reset value of every output is 0, except `cmd_ready`, which is 1. Internal counters clear to 0.
- Reset mid-operation:
  - Return to IDLE immediately.
  - Emit no `stop_req`.
  - Drop any pending `byte_done` on the floor.
- IDLE: `cmd_ready`=1. When `cmd_valid` is high, perform these actions and go to LOAD:
  - latch `cmd_dev`, `cmd_reg` and `cmd_data`;
  - set the byte index `idx`=0;
  - set `attempts`=1;
  - set `err_code`=00;
  - set `busy`=1.
- LOAD: assert `pre_ready` for exactly one cycle with `pre_data` set by `idx`:
  - `idx`=0: `{dev,1'b0}`;
  - `idx`=1: `reg`;
  - `idx`=2: `data`.
  - `pre_first` is high when `idx`=0; `pre_last` is high when `idx`=2.
  - Clear the timeout counter, then go to WAIT.
- WAIT: increment the timeout counter every cycle.
  - If `byte_done` is high, register `ack_n` and go to CHECK.
  - If the counter reaches `TIMEOUT-1` with no `byte_done`: pulse `stop_req`, set `err_code`=11, go to FIN with a failure result. Timeout is never retried.
  - If `byte_done` arrives in the same cycle the counter hits its limit, `byte_done` wins.
- CHECK:
  - On ACK with `idx`<2: increment `idx` and go to LOAD.
  - On ACK with `idx`=2: go to FIN with a success result.
  - On NACK: pulse `stop_req` and record `err_code` (01 if `idx`=0, otherwise 10).
    - If `attempts` ≤ `NUM_RETRY`: go to GAP.
    - Otherwise: go to FIN with a failure result.
  - After the final NACK there is no STOP from `pre_last`; `stop_req` alone ends the bus transaction.
- GAP: count `GAP_CYC` cycles, then perform these actions and go to LOAD:
  - set `idx`=0;
  - increment `attempts`;
  - clear `err_code` to 00.
- FIN: for exactly one cycle, pulse `done` or `err`, drop `busy`, and raise `cmd_ready`. Then go to IDLE.
- `byte_done` seen outside WAIT is ignored. `cmd_valid` while `cmd_ready`=0 is ignored, because the command registers are held.

## Timing
- Command accepted in cycle T → `pre_ready` for byte 0 in cycle T+1.
- `byte_done` with ACK in cycle D → next `pre_ready` in D+2 (CHECK, then LOAD).
- Last ACK in cycle D → `done` and `cmd_ready` in D+2. A new command can be accepted in D+2, with its `pre_ready` in D+3.
- NACK in cycle D → `stop_req` in D+1 and retry `pre_ready` in D+2+`GAP_CYC`.
- Timeout: `pre_ready` in cycle L → `stop_req` in L+`TIMEOUT` and `err` in L+`TIMEOUT`+1.
- `pre_data`, `pre_first` and `pre_last` are 0 whenever `pre_ready` is 0.

## Test plan
- Clean write:
  - Stimulus: dev=0x50, reg=0x10, data=0xA5; the engine model returns ACK 20 cycles after each load.
  - Required: `pre_data` sequence 0xA0, 0x10, 0xA5; `pre_first` only on 0xA0; `pre_last` only on 0xA5.
  - Required: `done` 2 cycles after the third `byte_done`; `attempts`=1; `err_code`=00.
- Address NACK then ACK:
  - Stimulus: NACK on byte 0 of the first attempt, then all ACK.
  - Required: `stop_req` 1 cycle after the NACK; retry `pre_ready` 18 cycles after the NACK with `GAP_CYC`=16.
  - Required: `done` at the end; `attempts`=2; `err_code`=00.
- Persistent data NACK:
  - Stimulus: NACK on byte 2 every attempt, `NUM_RETRY`=3.
  - Required: 4 attempts, 4 `stop_req` pulses, then `err` with `err_code`=10 and `attempts`=4.
- Timeout:
  - Stimulus: `TIMEOUT`=64; the engine never returns `byte_done` for byte 1.
  - Required: `stop_req` at load+64; `err` at load+65; `err_code`=11; no retry.
- Reset mid-transfer:
  - Stimulus: assert `rst` in WAIT of byte 1.
  - Required: next cycle `cmd_ready`=1 with every other output 0, including `busy`, `pre_ready`, `stop_req` and `err_code`.
  - Required: a stray `byte_done` after reset is ignored.
- Back-to-back commands with `cmd_valid` held high:
  - Required: the second command is accepted in the `done` cycle and its byte 0 loads on the following cycle.
  - Required: `cmd_dev`, `cmd_reg` and `cmd_data` changes while busy do not affect the in-flight bytes.

Source files
------------

// File: rtl/i2c_wr_seq_if.sv
// Register-write sequencer bus: command port plus the byte engine load/ACK handshake.
// master = sequencer side, slave = command source and byte engine side.
interface i2c_wr_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_data;
  logic       pre_ready;
  logic [7:0] pre_data;
  logic       pre_first;
  logic       pre_last;
  logic       byte_done;
  logic       ack_n;
  logic       stop_req;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic [2:0] attempts;

  modport master (
    input  cmd_valid, cmd_dev, cmd_reg, cmd_data, byte_done, ack_n,
    output cmd_ready, pre_ready, pre_data, pre_first, pre_last,
           stop_req, busy, done, err, err_code, attempts
  );

  modport slave (
    output cmd_valid, cmd_dev, cmd_reg, cmd_data, byte_done, ack_n,
    input  cmd_ready, pre_ready, pre_data, pre_first, pre_last,
           stop_req, busy, done, err, err_code, attempts
  );
endinterface

// File: rtl/i2c_wr_seq.sv
// Turns one register-write command into dev/reg/data byte loads, retrying on NACK and aborting on timeout.
// Command to first load 1 cycle, ACK to next load 2 cycles; commands are only taken when cmd_ready is high.
module i2c_wr_seq #(
  parameter int NUM_RETRY = 3,
  parameter int TIMEOUT   = 4096,
  parameter int GAP_CYC   = 16
) (
  input  logic         clk,
  input  logic         rst,
  i2c_wr_seq_if.master bus
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, CHECK, GAP, FIN} state_t;

  typedef struct packed {
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] dat;
  } cmd_t;

  localparam int             TW        = $clog2(TIMEOUT + 1);
  localparam int             GW        = $clog2(GAP_CYC + 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0]  GAP_LAST  = GW'(GAP_CYC - 1);
  localparam logic [3:0]     RETRY_MAX = 4'(NUM_RETRY);

  state_t        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [1:0]    idx_q, idx_d;
  // One bit wider than the reported count so NUM_RETRY=7 still terminates
  logic [3:0]    att_q, att_d;
  logic [1:0]    code_q, code_d;
  logic          ack_q, ack_d;
  logic          ok_q, ok_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          take;

  assign bus.err_code = code_q;
  assign bus.attempts = att_q[2:0];

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    idx_d         = idx_q;
    att_d         = att_q;
    code_d        = code_q;
    ack_d         = ack_q;
    ok_d          = ok_q;
    tmo_d         = tmo_q;
    gap_d         = gap_q;
    take          = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.pre_ready = 1'b0;
    bus.pre_data  = 8'h00;
    bus.pre_first = 1'b0;
    bus.pre_last  = 1'b0;
    bus.stop_req  = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    bus.err       = 1'b0;

    case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
        take          = bus.cmd_valid;
      end
      LOAD: begin
        bus.pre_ready = 1'b1;
        case (idx_q)
          2'd0: begin
            bus.pre_data  = {cmd_q.dev, 1'b0};
            bus.pre_first = 1'b1;
          end
          2'd1: bus.pre_data = cmd_q.rg;
          default: begin
            bus.pre_data = cmd_q.dat;
            bus.pre_last = 1'b1;
          end
        endcase
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // A byte_done landing on the last counted cycle still counts as a response
        if (bus.byte_done) begin
          ack_d   = bus.ack_n;
          state_d = CHECK;
        end else if (tmo_q == TMO_LAST) begin
          bus.stop_req = 1'b1;
          code_d       = 2'b11;
          ok_d         = 1'b0;
          state_d      = FIN;
        end
      end
      CHECK: begin
        if (!ack_q) begin
          if (idx_q == 2'd2) begin
            ok_d    = 1'b1;
            state_d = FIN;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = LOAD;
          end
        end else begin
          bus.stop_req = 1'b1;
          code_d       = (idx_q == 2'd0) ? 2'b01 : 2'b10;
          if (att_q <= RETRY_MAX) begin
            gap_d   = '0;
            state_d = GAP;
          end else begin
            ok_d    = 1'b0;
            state_d = FIN;
          end
        end
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          idx_d   = 2'd0;
          att_d   = att_q + 4'd1;
          code_d  = 2'b00;
          state_d = LOAD;
        end
      end
      FIN: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
        bus.done      = ok_q;
        bus.err       = ~ok_q;
        state_d       = IDLE;
        take          = bus.cmd_valid;
      end
      default: state_d = IDLE;
    endcase

    // Acceptance from FIN lets a held cmd_valid start the next write without an IDLE cycle
    if (take) begin
      cmd_d   = '{dev: bus.cmd_dev, rg: bus.cmd_reg, dat: bus.cmd_data};
      idx_d   = 2'd0;
      att_d   = 4'd1;
      code_d  = 2'b00;
      state_d = LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      idx_q   <= '0;
      att_q   <= '0;
      code_q  <= '0;
      ack_q   <= 1'b0;
      ok_q    <= 1'b0;
      tmo_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      att_q   <= att_d;
      code_q  <= code_d;
      ack_q   <= ack_d;
      ok_q    <= ok_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_i2c_wr_seq.sv
// Bench for i2c_wr_seq: directed scenarios plus randomized writes scored against a timeline model.
// The byte engine is modelled by a response schedule keyed on attempt number and byte index.
module tb_i2c_wr_seq;
  localparam int NR  = 3;
  localparam int TMO = 64;
  localparam int GAP = 16;

  logic clk = 1'b0;
  logic rst;
  i2c_wr_seq_if bus();

  i2c_wr_seq #(.NUM_RETRY(NR), .TIMEOUT(TMO), .GAP_CYC(GAP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int         cyc;
    logic [7:0] d;
    logic       f;
    logic       l;
  } load_t;

  int total = 0;
  int bad   = 0;

  load_t      obs_load[$], exp_load[$];
  int         obs_stop[$], exp_stop[$];
  int         pend_due[$];
  logic       pend_ack[$];
  int         obs_kind, obs_fin, viol;
  logic [1:0] obs_code;
  logic [2:0] obs_att;
  int         exp_kind, exp_fin;
  logic [1:0] exp_code;
  logic [2:0] exp_att;
  int         plan_nack[10];
  int         plan_tmo[10];

  task automatic clear_plan();
    for (int i = 0; i < 10; i++) begin
      plan_nack[i] = -1;
      plan_tmo[i]  = -1;
    end
  endtask

  // Presents a command (unless already accepted) and plays the byte engine until done/err or budget.
  task automatic run_txn(input logic [6:0] dv, input logic [7:0] rg, input logic [7:0] dt,
                         input int dly, input bit pre_acc, input bit nxt_vld,
                         input logic [6:0] ndv, input logic [7:0] nrg, input logic [7:0] ndt,
                         output int acc);
    int att_i = 0;
    int b;
    bit fin = 0;
    obs_load.delete(); obs_stop.delete(); pend_due.delete(); pend_ack.delete();
    obs_kind = 0; obs_fin = -1; obs_code = 2'b00; obs_att = 3'd0; viol = 0;
    if (!pre_acc) begin
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_dev = dv; bus.cmd_reg = rg; bus.cmd_data = dt;
      bus.byte_done = 1'b0;
      #1;
      if (!bus.cmd_ready) viol++;
    end
    acc = cyc;
    for (int k = 0; k < 3000 && !fin; k++) begin
      @(negedge clk);
      bus.cmd_valid = nxt_vld;
      bus.cmd_dev   = nxt_vld ? ndv : 7'($urandom);
      bus.cmd_reg   = nxt_vld ? nrg : 8'($urandom);
      bus.cmd_data  = nxt_vld ? ndt : 8'($urandom);
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        bus.byte_done = 1'b1;
        bus.ack_n     = pend_ack.pop_front();
        void'(pend_due.pop_front());
      end else begin
        bus.byte_done = 1'b0;
        bus.ack_n     = 1'($urandom);
      end
      #1;
      if (bus.pre_ready) begin
        obs_load.push_back(load_t'{cyc, bus.pre_data, bus.pre_first, bus.pre_last});
        if (bus.pre_first && att_i < 9) att_i++;
        b = bus.pre_first ? 0 : (bus.pre_last ? 2 : 1);
        if (plan_tmo[att_i] != b) begin
          pend_due.push_back(cyc + dly);
          pend_ack.push_back(plan_nack[att_i] == b);
        end
      end else if (bus.pre_data != 8'h00 || bus.pre_first || bus.pre_last) viol++;
      if (bus.stop_req) obs_stop.push_back(cyc);
      if (bus.done || bus.err) begin
        fin      = 1;
        obs_kind = (bus.done && bus.err) ? 3 : (bus.done ? 1 : 2);
        obs_fin  = cyc;
        obs_code = bus.err_code;
        obs_att  = bus.attempts;
        if (bus.busy || !bus.cmd_ready) viol++;
      end else if (!bus.busy || bus.cmd_ready) viol++;
    end
  endtask

  // Expected timeline derived from the protocol timing rules with plain arithmetic.
  task automatic model_txn(input int acc, input int dly, input logic [6:0] dv,
                           input logic [7:0] rg, input logic [7:0] dt);
    logic [7:0] by[3];
    int t, a, d;
    bit fin;
    by[0] = {dv, 1'b0}; by[1] = rg; by[2] = dt;
    exp_load.delete(); exp_stop.delete();
    t = acc + 1; a = 1; fin = 0;
    while (!fin && a <= 9) begin
      for (int b = 0; b < 3; b++) begin
        exp_load.push_back(load_t'{t, by[b], b == 0, b == 2});
        if (plan_tmo[a] == b) begin
          exp_stop.push_back(t + TMO);
          exp_kind = 2; exp_fin = t + TMO + 1; exp_code = 2'b11; exp_att = 3'(a);
          fin = 1;
          break;
        end
        d = t + dly;
        if (plan_nack[a] == b) begin
          exp_stop.push_back(d + 1);
          if (a <= NR) begin
            t = d + 2 + GAP;
            a++;
          end else begin
            exp_kind = 2; exp_fin = d + 2; exp_code = (b == 0) ? 2'b01 : 2'b10; exp_att = 3'(a);
            fin = 1;
          end
          break;
        end
        if (b < 2) t = d + 2;
        else begin
          exp_kind = 1; exp_fin = d + 2; exp_code = 2'b00; exp_att = 3'(a);
          fin = 1;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [20:0] v;
    rst = 1'b1;
    bus.cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    v = {bus.cmd_ready, bus.pre_ready, bus.pre_data, bus.pre_first, bus.pre_last, bus.stop_req,
         bus.busy, bus.done, bus.err, bus.err_code, bus.attempts};
    total++; if (v !== 21'h100000) begin bad++; $display("FAIL reset_outputs got=%h want=%h", v, 21'h100000); end
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean();
    int acc;
    logic [7:0] wd[3];
    wd[0] = 8'hA0; wd[1] = 8'h10; wd[2] = 8'hA5;
    clear_plan();
    run_txn(7'h50, 8'h10, 8'hA5, 20, 0, 0, 7'h0, 8'h0, 8'h0, acc);
    total++; if (obs_load.size() !== 3) begin bad++; $display("FAIL clean_nloads got=%0d want=3", obs_load.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < obs_load.size()) begin
        total++;
        if (obs_load[i] !== load_t'{acc + 1 + 22 * i, wd[i], i == 0, i == 2}) begin
          bad++; $display("FAIL clean_load%0d got=%h want=%h", i, obs_load[i], load_t'{acc + 1 + 22 * i, wd[i], i == 0, i == 2});
        end
      end
    end
    total++; if (obs_kind !== 1) begin bad++; $display("FAIL clean_kind got=%0d want=1", obs_kind); end
    total++; if (obs_fin !== acc + 67) begin bad++; $display("FAIL clean_done_cyc got=%0d want=%0d", obs_fin, acc + 67); end
    total++; if (obs_att !== 3'd1) begin bad++; $display("FAIL clean_attempts got=%0d want=1", obs_att); end
    total++; if (obs_code !== 2'b00) begin bad++; $display("FAIL clean_err_code got=%0d want=0", obs_code); end
    total++; if (obs_stop.size() !== 0) begin bad++; $display("FAIL clean_stops got=%0d want=0", obs_stop.size()); end
    total++; if (viol !== 0) begin bad++; $display("FAIL clean_protocol got=%0d want=0", viol); end
  endtask

  task automatic test_addr_nack();
    int acc;
    logic [6:0] dv = 7'($urandom);
    logic [7:0] rg = 8'($urandom);
    logic [7:0] dt = 8'($urandom);
    clear_plan();
    plan_nack[1] = 0;
    run_txn(dv, rg, dt, 20, 0, 0, 7'h0, 8'h0, 8'h0, acc);
    total++; if (obs_stop.size() !== 1) begin bad++; $display("FAIL anack_nstops got=%0d want=1", obs_stop.size()); end
    if (obs_stop.size() > 0) begin
      total++; if (obs_stop[0] !== acc + 22) begin bad++; $display("FAIL anack_stop_cyc got=%0d want=%0d", obs_stop[0], acc + 22); end
    end
    total++; if (obs_load.size() !== 4) begin bad++; $display("FAIL anack_nloads got=%0d want=4", obs_load.size()); end
    if (obs_load.size() > 1) begin
      total++;
      if (obs_load[1] !== load_t'{acc + 39, {dv, 1'b0}, 1'b1, 1'b0}) begin
        bad++; $display("FAIL anack_retry_load got=%h want=%h", obs_load[1], load_t'{acc + 39, {dv, 1'b0}, 1'b1, 1'b0});
      end
    end
    total++; if (obs_kind !== 1) begin bad++; $display("FAIL anack_kind got=%0d want=1", obs_kind); end
    total++; if (obs_fin !== acc + 105) begin bad++; $display("FAIL anack_done_cyc got=%0d want=%0d", obs_fin, acc + 105); end
    total++; if (obs_att !== 3'd2) begin bad++; $display("FAIL anack_attempts got=%0d want=2", obs_att); end
    total++; if (obs_code !== 2'b00) begin bad++; $display("FAIL anack_err_code got=%0d want=0", obs_code); end
  endtask

  task automatic test_data_nack();
    int acc, s;
    int dly = $urandom_range(5, 30);
    clear_plan();
    for (int a = 1; a <= 4; a++) plan_nack[a] = 2;
    run_txn(7'($urandom), 8'($urandom), 8'($urandom), dly, 0, 0, 7'h0, 8'h0, 8'h0, acc);
    total++; if (obs_load.size() !== 12) begin bad++; $display("FAIL dnack_nloads got=%0d want=12", obs_load.size()); end
    total++; if (obs_stop.size() !== 4) begin bad++; $display("FAIL dnack_nstops got=%0d want=4", obs_stop.size()); end
    s = acc + 1;
    for (int k = 0; k < 4; k++) begin
      if (k < obs_stop.size()) begin
        total++;
        if (obs_stop[k] !== s + 3 * dly + 5) begin bad++; $display("FAIL dnack_stop%0d got=%0d want=%0d", k, obs_stop[k], s + 3 * dly + 5); end
      end
      if (k < 3) s = s + 3 * dly + 6 + GAP;
    end
    total++; if (obs_kind !== 2) begin bad++; $display("FAIL dnack_kind got=%0d want=2", obs_kind); end
    total++; if (obs_fin !== s + 3 * dly + 6) begin bad++; $display("FAIL dnack_err_cyc got=%0d want=%0d", obs_fin, s + 3 * dly + 6); end
    total++; if (obs_code !== 2'b10) begin bad++; $display("FAIL dnack_err_code got=%0d want=2", obs_code); end
    total++; if (obs_att !== 3'd4) begin bad++; $display("FAIL dnack_attempts got=%0d want=4", obs_att); end
  endtask

  task automatic test_timeout();
    int acc, l1, cnt;
    int dly = $urandom_range(2, 30);
    clear_plan();
    plan_tmo[1] = 1;
    run_txn(7'($urandom), 8'($urandom), 8'($urandom), dly, 0, 0, 7'h0, 8'h0, 8'h0, acc);
    l1 = acc + 1 + dly + 2;
    total++; if (obs_load.size() !== 2) begin bad++; $display("FAIL tmo_nloads got=%0d want=2", obs_load.size()); end
    if (obs_load.size() > 1) begin
      total++; if (obs_load[1].cyc !== l1) begin bad++; $display("FAIL tmo_load1_cyc got=%0d want=%0d", obs_load[1].cyc, l1); end
    end
    total++; if (obs_stop.size() !== 1) begin bad++; $display("FAIL tmo_nstops got=%0d want=1", obs_stop.size()); end
    if (obs_stop.size() > 0) begin
      total++; if (obs_stop[0] !== l1 + TMO) begin bad++; $display("FAIL tmo_stop_cyc got=%0d want=%0d", obs_stop[0], l1 + TMO); end
    end
    total++; if (obs_kind !== 2) begin bad++; $display("FAIL tmo_kind got=%0d want=2", obs_kind); end
    total++; if (obs_fin !== l1 + TMO + 1) begin bad++; $display("FAIL tmo_err_cyc got=%0d want=%0d", obs_fin, l1 + TMO + 1); end
    total++; if (obs_code !== 2'b11) begin bad++; $display("FAIL tmo_err_code got=%0d want=3", obs_code); end
    total++; if (obs_att !== 3'd1) begin bad++; $display("FAIL tmo_attempts got=%0d want=1", obs_att); end
    cnt = 0;
    repeat (30) begin
      @(negedge clk); #1;
      if (bus.pre_ready || bus.busy) cnt++;
    end
    total++; if (cnt !== 0) begin bad++; $display("FAIL tmo_no_retry got=%0d want=0", cnt); end
  endtask

  task automatic test_rst_mid();
    logic [20:0] v;
    int due = -1;
    int cnt = 0;
    bit seen = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_dev = 7'($urandom); bus.cmd_reg = 8'($urandom); bus.cmd_data = 8'($urandom);
    bus.byte_done = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.byte_done = (cyc == due);
      bus.ack_n     = 1'b0;
      #1;
      if (bus.pre_ready && bus.pre_first) due = cyc + 5;
      if (bus.pre_ready && !bus.pre_first) seen = 1;
    end
    total++; if (!seen) begin bad++; $display("FAIL rstmid_reach_byte1 got=0 want=1"); end
    @(negedge clk); bus.byte_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    v = {bus.cmd_ready, bus.pre_ready, bus.pre_data, bus.pre_first, bus.pre_last, bus.stop_req,
         bus.busy, bus.done, bus.err, bus.err_code, bus.attempts};
    total++; if (v !== 21'h100000) begin bad++; $display("FAIL rstmid_outputs got=%h want=%h", v, 21'h100000); end
    @(negedge clk);
    bus.byte_done = 1'b1; bus.ack_n = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      v = {bus.cmd_ready, bus.pre_ready, bus.pre_data, bus.pre_first, bus.pre_last, bus.stop_req,
           bus.busy, bus.done, bus.err, bus.err_code, bus.attempts};
      if (v !== 21'h100000) cnt++;
      @(negedge clk);
      bus.byte_done = 1'b0;
    end
    total++; if (cnt !== 0) begin bad++; $display("FAIL rstmid_stray_done got=%0d want=0", cnt); end
  endtask

  task automatic test_back_to_back();
    int acc_a, acc_b, fin_a, s;
    logic [7:0] wa[3], wb[3];
    logic [6:0] dv = 7'($urandom);
    logic [7:0] rg = 8'($urandom);
    logic [7:0] dt = 8'($urandom);
    logic [6:0] ndv = dv ^ 7'h55;
    logic [7:0] nrg = rg ^ 8'hFF;
    logic [7:0] ndt = dt ^ 8'h3C;
    int dly = $urandom_range(1, 40);
    wa[0] = {dv, 1'b0};  wa[1] = rg;  wa[2] = dt;
    wb[0] = {ndv, 1'b0}; wb[1] = nrg; wb[2] = ndt;
    clear_plan();
    run_txn(dv, rg, dt, dly, 0, 1, ndv, nrg, ndt, acc_a);
    fin_a = obs_fin;
    total++; if (obs_kind !== 1) begin bad++; $display("FAIL b2b_a_kind got=%0d want=1", obs_kind); end
    total++; if (fin_a !== acc_a + 3 * dly + 7) begin bad++; $display("FAIL b2b_a_done_cyc got=%0d want=%0d", fin_a, acc_a + 3 * dly + 7); end
    for (int i = 0; i < 3; i++) begin
      if (i < obs_load.size()) begin
        total++; if (obs_load[i].d !== wa[i]) begin bad++; $display("FAIL b2b_a_byte%0d got=%h want=%h", i, obs_load[i].d, wa[i]); end
      end
    end
    run_txn(ndv, nrg, ndt, dly, 1, 0, 7'h0, 8'h0, 8'h0, acc_b);
    s = fin_a + 1;
    for (int i = 0; i < 3; i++) begin
      if (i < obs_load.size()) begin
        total++;
        if (obs_load[i] !== load_t'{s + i * (dly + 2), wb[i], i == 0, i == 2}) begin
          bad++; $display("FAIL b2b_b_load%0d got=%h want=%h", i, obs_load[i], load_t'{s + i * (dly + 2), wb[i], i == 0, i == 2});
        end
      end
    end
    total++; if (obs_load.size() !== 3) begin bad++; $display("FAIL b2b_b_nloads got=%0d want=3", obs_load.size()); end
    total++; if (obs_kind !== 1) begin bad++; $display("FAIL b2b_b_kind got=%0d want=1", obs_kind); end
    total++; if (obs_fin !== s + 3 * dly + 6) begin bad++; $display("FAIL b2b_b_done_cyc got=%0d want=%0d", obs_fin, s + 3 * dly + 6); end
  endtask

  task automatic test_random();
    int acc, dly, r;
    logic [6:0] dv;
    logic [7:0] rg, dt;
    for (int t = 0; t < 30; t++) begin
      clear_plan();
      for (int a = 1; a <= 4; a++) begin
        r = $urandom_range(0, 11);
        if (r < 3) plan_nack[a] = r;
        else if (r == 3) plan_tmo[a] = $urandom_range(0, 2);
      end
      dly = (t == 0) ? TMO : ((t == 1) ? 1 : $urandom_range(1, TMO));
      dv = 7'($urandom); rg = 8'($urandom); dt = 8'($urandom);
      run_txn(dv, rg, dt, dly, 0, 0, 7'h0, 8'h0, 8'h0, acc);
      model_txn(acc, dly, dv, rg, dt);
      total++; if (obs_load.size() !== exp_load.size()) begin bad++; $display("FAIL rnd%0d_nloads got=%0d want=%0d", t, obs_load.size(), exp_load.size()); end
      for (int i = 0; i < exp_load.size() && i < obs_load.size(); i++) begin
        total++; if (obs_load[i] !== exp_load[i]) begin bad++; $display("FAIL rnd%0d_load%0d got=%h want=%h", t, i, obs_load[i], exp_load[i]); end
      end
      total++; if (obs_stop.size() !== exp_stop.size()) begin bad++; $display("FAIL rnd%0d_nstops got=%0d want=%0d", t, obs_stop.size(), exp_stop.size()); end
      for (int i = 0; i < exp_stop.size() && i < obs_stop.size(); i++) begin
        total++; if (obs_stop[i] !== exp_stop[i]) begin bad++; $display("FAIL rnd%0d_stop%0d got=%0d want=%0d", t, i, obs_stop[i], exp_stop[i]); end
      end
      total++; if (obs_kind !== exp_kind) begin bad++; $display("FAIL rnd%0d_kind got=%0d want=%0d", t, obs_kind, exp_kind); end
      total++; if (obs_fin !== exp_fin) begin bad++; $display("FAIL rnd%0d_fin_cyc got=%0d want=%0d", t, obs_fin, exp_fin); end
      total++; if (obs_code !== exp_code) begin bad++; $display("FAIL rnd%0d_err_code got=%0d want=%0d", t, obs_code, exp_code); end
      total++; if (obs_att !== exp_att) begin bad++; $display("FAIL rnd%0d_attempts got=%0d want=%0d", t, obs_att, exp_att); end
      total++; if (viol !== 0) begin bad++; $display("FAIL rnd%0d_protocol got=%0d want=0", t, viol); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_dev   = 7'h0;
    bus.cmd_reg   = 8'h0;
    bus.cmd_data  = 8'h0;
    bus.byte_done = 1'b0;
    bus.ack_n     = 1'b0;
    test_reset();
    test_clean();
    test_addr_nack();
    test_data_nack();
    test_timeout();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
